// File: rtl/sdiomux_xcvr.sv
// ----------------------------------------------------------------------------
// sdiomux_xcvr
//
// Half-duplex serial transceiver for one shared SDIO-style data pad. It drives
// a frame out (TX) or samples a frame in (RX), never both. Every change of
// bus direction is followed by a TURN gap with both pad enables released.
//
// Parameters
//   WIDTH        frame data width in bits (2..32)
//   TURN_CYCLES  bus-turnaround gap in cycles (1..15)
//
// Optional feature
//   SDIOMUX_XCVR_PARITY_EN  when defined, an even-parity bit follows the LSB
//                           (frame length F = WIDTH+1). RX sets RX_PERR on a
//                           mismatch. When undefined F = WIDTH and RX_PERR
//                           is tied low.
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST        synchronous active-high reset
//   TX_DATA    word to transmit, MSB first
//   TX_VALID   transmit request
//   TX_READY   high only in IDLE
//   RX_START   receive request, only looked at in IDLE
//   RX_DATA    last received word (holds between receptions)
//   RX_VALID   one-cycle pulse when RX_DATA updates
//   RX_PERR    parity error flag for the current RX_DATA
//   O_DAT      pad output data
//   O_EN       pad drive enable, active low
//   I_EN       pad input enable, active low
//   I_DAT      pad input data, asynchronous to CLK
//   BUSY       high in every state except IDLE
//   dbg_state  current FSM state (0 IDLE, 1 TX, 2 RX, 3 TURN)
//
// Handshake: a word is taken when TX_VALID and TX_READY are both high at a
// rising edge of CLK; TX_VALID wins over RX_START in the same cycle.
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module sdiomux_xcvr #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    input  logic             RX_START,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             RX_PERR,
    output logic             O_DAT,
    output logic             O_EN,
    output logic             I_EN,
    input  logic             I_DAT,
    output logic             BUSY,
    output logic [1:0]       dbg_state
);

`ifdef SDIOMUX_XCVR_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int F = WIDTH + PAR_BITS;

    // Last value of the shared cycle counter in each timed state.
    localparam logic [5:0] TX_LAST   = 6'(F - 1);
    localparam logic [5:0] RX_LAST   = 6'(F + 1);
    localparam logic [5:0] TURN_LAST = 6'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_RX   = 2'd2,
        S_TURN = 2'd3
    } state_t;

    state_t         state;
    logic [5:0]     cnt;
    logic [F-1:0]   tx_sh;
    logic [F-2:0]   rx_sh;
    logic           sync1;
    logic           sync2;
    logic [F-1:0]   tx_frame;
    logic [F-1:0]   rx_word;

`ifdef SDIOMUX_XCVR_PARITY_EN
    assign tx_frame = {TX_DATA, ^TX_DATA};
`else
    assign tx_frame = TX_DATA;
    assign RX_PERR  = 1'b0;
`endif

    // Frame as it stands once the current synchronizer output is shifted in;
    // used both for the shift and for the final word at the end of RX.
    assign rx_word   = {rx_sh, sync2};
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            TX_READY <= 1'b1;
            BUSY     <= 1'b0;
            O_DAT    <= 1'b0;
            O_EN     <= 1'b1;
            I_EN     <= 1'b1;
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
`ifdef SDIOMUX_XCVR_PARITY_EN
            RX_PERR  <= 1'b0;
`endif
        end else begin
            // I_DAT comes from the pad with no timing relation to CLK.
            sync1    <= I_DAT;
            sync2    <= sync1;
            RX_VALID <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (TX_VALID && TX_READY) begin
                        // First bit goes out on the accept edge itself.
                        state    <= S_TX;
                        TX_READY <= 1'b0;
                        BUSY     <= 1'b1;
                        O_EN     <= 1'b0;
                        O_DAT    <= tx_frame[F-1];
                        tx_sh    <= {tx_frame[F-2:0], 1'b0};
                        cnt      <= '0;
                    end else if (RX_START) begin
                        state    <= S_RX;
                        TX_READY <= 1'b0;
                        BUSY     <= 1'b1;
                        I_EN     <= 1'b0;
                        rx_sh    <= '0;
                        cnt      <= '0;
                    end
                end

                S_TX: begin
                    if (cnt == TX_LAST) begin
                        state <= S_TURN;
                        O_EN  <= 1'b1;
                        O_DAT <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        O_DAT <= tx_sh[F-1];
                        tx_sh <= {tx_sh[F-2:0], 1'b0};
                        cnt   <= cnt + 6'd1;
                    end
                end

                S_RX: begin
                    // The first two synchronizer outputs predate the remote
                    // driver's first bit and are skipped.
                    if (cnt >= 6'd2) begin
                        rx_sh <= rx_word[F-2:0];
                    end
                    if (cnt == RX_LAST) begin
                        state    <= S_TURN;
                        I_EN     <= 1'b1;
                        RX_DATA  <= rx_word[F-1 -: WIDTH];
                        RX_VALID <= 1'b1;
`ifdef SDIOMUX_XCVR_PARITY_EN
                        // Even parity: an odd count of ones is an error.
                        RX_PERR  <= ^rx_word;
`endif
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end

                S_TURN: begin
                    if (cnt == TURN_LAST) begin
                        state    <= S_IDLE;
                        TX_READY <= 1'b1;
                        BUSY     <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    TX_READY <= 1'b1;
                    BUSY     <= 1'b0;
                    O_EN     <= 1'b1;
                    I_EN     <= 1'b1;
                    O_DAT    <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdiomux_xcvr.sv
// ----------------------------------------------------------------------------
// tb_sdiomux_xcvr
//
// Self-checking bench for sdiomux_xcvr with WIDTH=8, TURN_CYCLES=2. Expected
// pad waveforms and received words are derived from the frame rules (bit
// order, parity, cycle counts) by the functions below. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_sdiomux_xcvr;

    localparam int W = 8;
    localparam int T = 2;
`ifdef SDIOMUX_XCVR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F = W + PAR;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] TX_DATA = '0;
    logic         TX_VALID = 1'b0;
    logic         TX_READY;
    logic         RX_START = 1'b0;
    logic [W-1:0] RX_DATA;
    logic         RX_VALID;
    logic         RX_PERR;
    logic         O_DAT;
    logic         O_EN;
    logic         I_EN;
    logic         I_DAT = 1'b0;
    logic         BUSY;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    sdiomux_xcvr #(.WIDTH(W), .TURN_CYCLES(T)) dut (
        .CLK(CLK), .RST(RST),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_START(RX_START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_PERR(RX_PERR), .O_DAT(O_DAT), .O_EN(O_EN), .I_EN(I_EN),
        .I_DAT(I_DAT), .BUSY(BUSY), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The pad must never be driven and listened to at the same time.
    always @(negedge CLK) begin
        n_checks++;
        if (!O_EN && !I_EN) begin
            n_fail++;
            $display("FAIL pad_contention: O_EN=%b I_EN=%b at %0t", O_EN, I_EN, $time);
        end
    end

    // ---------------- reference model ----------------
    // Serial frame as it must appear on O_DAT, first bit at the MSB.
    function automatic logic [F-1:0] model_frame(input logic [W-1:0] d);
        logic [F-1:0] f;
        f = '0;
        for (int i = 0; i < W; i++) f[F-1-i] = d[W-1-i];
        if (PAR == 1) f[0] = (($countones(d) % 2) == 1);
        return f;
    endfunction

    function automatic logic [W-1:0] model_rx_data(input logic [F-1:0] line);
        logic [W-1:0] d;
        for (int i = 0; i < W; i++) d[W-1-i] = line[F-1-i];
        return d;
    endfunction

    function automatic logic model_rx_perr(input logic [F-1:0] line);
        return (PAR == 1) && (($countones(line) % 2) == 1);
    endfunction

    // ---------------- driver tasks ----------------
    // Advance to a falling edge in IDLE (TX_READY high), bounded.
    task automatic wait_idle();
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK);
            if (TX_READY) seen = 1;
        end
        check("idle_timeout", 32'(seen), 32'd1);
    endtask

    task automatic noise_inputs(input bit noise);
        TX_VALID = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        RX_START = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        TX_DATA  = W'($urandom);
    endtask

    task automatic tx_frame(input logic [W-1:0] word, input logic [F-1:0] exp_bits,
                            input bit also_rx, input bit noise);
        wait_idle();
        TX_DATA  = word;
        TX_VALID = 1'b1;
        RX_START = also_rx;
        @(posedge CLK);
        for (int i = 0; i < F; i++) begin
            @(negedge CLK);
            noise_inputs(noise);
            check("tx_oen", 32'(O_EN), 32'd0);
            check("tx_ien", 32'(I_EN), 32'd1);
            check("tx_bit", 32'(O_DAT), 32'(exp_bits[F-1-i]));
            check("tx_busy", 32'(BUSY), 32'd1);
        end
        for (int i = 0; i < T; i++) begin
            @(negedge CLK);
            noise_inputs(noise);
            check("tx_turn_oen", 32'(O_EN), 32'd1);
            check("tx_turn_ien", 32'(I_EN), 32'd1);
            check("tx_turn_odat", 32'(O_DAT), 32'd0);
            check("tx_turn_ready", 32'(TX_READY), 32'd0);
        end
        @(negedge CLK);
        TX_VALID = 1'b0;
        RX_START = 1'b0;
        check("tx_end_ready", 32'(TX_READY), 32'd1);
        check("tx_end_busy", 32'(BUSY), 32'd0);
        check("tx_end_ien", 32'(I_EN), 32'd1);
    endtask

    task automatic rx_frame(input logic [F-1:0] line, input logic [W-1:0] exp_data,
                            input logic exp_perr, input bit noise);
        wait_idle();
        TX_VALID = 1'b0;
        RX_START = 1'b1;
        @(posedge CLK);
        // Remote drives bit k during the (k+1)-th cycle of I_EN low.
        for (int i = 1; i <= F + 2; i++) begin
            @(negedge CLK);
            noise_inputs(noise);
            I_DAT = (i <= F) ? line[F-i] : 1'($urandom_range(0, 1));
            check("rx_ien_low", 32'(I_EN), 32'd0);
            check("rx_oen", 32'(O_EN), 32'd1);
            check("rx_valid_early", 32'(RX_VALID), 32'd0);
        end
        @(negedge CLK);
        noise_inputs(noise);
        check("rx_ien_release", 32'(I_EN), 32'd1);
        check("rx_valid", 32'(RX_VALID), 32'd1);
        check("rx_data", 32'(RX_DATA), 32'(exp_data));
        check("rx_perr", 32'(RX_PERR), 32'(exp_perr));
        for (int i = 1; i < T; i++) begin
            @(negedge CLK);
            noise_inputs(noise);
            check("rx_valid_pulse", 32'(RX_VALID), 32'd0);
        end
        @(negedge CLK);
        TX_VALID = 1'b0;
        RX_START = 1'b0;
        check("rx_end_ready", 32'(TX_READY), 32'd1);
        check("rx_end_valid", 32'(RX_VALID), 32'd0);
        check("rx_hold_data", 32'(RX_DATA), 32'(exp_data));
        check("rx_hold_perr", 32'(RX_PERR), 32'(exp_perr));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit           is_rx;
        logic [W-1:0] word;      // TX input word
        logic [F-1:0] bits;      // TX: expected O_DAT sequence / RX: line bits
        logic [W-1:0] exp_data;  // RX expected word
        logic         exp_perr;  // RX expected parity flag
    } vec_t;

    vec_t vecs[4];

    // ---------------- main sequence ----------------
    initial begin
        logic [F-1:0] line;
        logic [W-1:0] w;
        logic         oen_s[64];
        logic         odat_s[64];
        int           gap;
        int           nsamp;

`ifdef SDIOMUX_XCVR_PARITY_EN
        vecs[0] = '{0, 8'hA5, 9'b101001010, 8'h00, 1'b0};
        vecs[1] = '{0, 8'h07, 9'b000001111, 8'h00, 1'b0};
        vecs[2] = '{1, 8'h00, 9'b000001110, 8'h07, 1'b1};
        vecs[3] = '{1, 8'h00, 9'b001111000, 8'h3C, 1'b0};
`else
        vecs[0] = '{0, 8'hA5, 8'b10100101, 8'h00, 1'b0};
        vecs[1] = '{0, 8'h00, 8'b00000000, 8'h00, 1'b0};
        vecs[2] = '{1, 8'h00, 8'b00111100, 8'h3C, 1'b0};
        vecs[3] = '{1, 8'h00, 8'b10000001, 8'h81, 1'b0};
`endif

        // Reset values.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_oen", 32'(O_EN), 32'd1);
        check("rst_ien", 32'(I_EN), 32'd1);
        check("rst_odat", 32'(O_DAT), 32'd0);
        check("rst_rx_data", 32'(RX_DATA), 32'd0);
        check("rst_rx_valid", 32'(RX_VALID), 32'd0);
        check("rst_rx_perr", 32'(RX_PERR), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_rst", 32'(TX_READY), 32'd1);

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].is_rx) rx_frame(vecs[v].bits, vecs[v].exp_data, vecs[v].exp_perr, 0);
            else               tx_frame(vecs[v].word, vecs[v].bits, 0, 0);
        end

        // TX_VALID and RX_START together: TX wins, RX request dropped.
        tx_frame(8'hFF, model_frame(8'hFF), 1, 0);
        @(negedge CLK);
        check("collide_no_rx_busy", 32'(BUSY), 32'd0);
        check("collide_no_rx_ien", 32'(I_EN), 32'd1);

        // Reset after three TX bits.
        wait_idle();
        TX_DATA  = 8'hA5;
        TX_VALID = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            TX_VALID = 1'b0;
            check("abort_tx_bit", 32'(O_DAT), 32'(model_frame(8'hA5) >> (F - 1 - i)) & 32'd1);
        end
        RST = 1'b1;
        @(negedge CLK);
        check("abort_tx_oen", 32'(O_EN), 32'd1);
        check("abort_tx_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("abort_tx_ready", 32'(TX_READY), 32'd1);
        for (int i = 0; i < F + T; i++) begin
            @(negedge CLK);
            check("abort_tx_quiet", 32'({O_DAT, O_EN}), 32'b01);
        end

        // Reset in the middle of a reception: no RX_VALID, data stays cleared.
        wait_idle();
        RX_START = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            RX_START = 1'b0;
            I_DAT = 1'b1;
        end
        RST = 1'b1;
        @(negedge CLK);
        check("abort_rx_ien", 32'(I_EN), 32'd1);
        RST = 1'b0;
        for (int i = 0; i < F + T + 4; i++) begin
            @(negedge CLK);
            check("abort_rx_quiet", 32'({RX_VALID, RX_DATA}), 32'd0);
        end

        // Back-to-back TX with TX_VALID held.
        wait_idle();
        TX_DATA  = 8'h5A;
        TX_VALID = 1'b1;
        @(posedge CLK);
        nsamp = 2 * F + 2 * T + 2;
        for (int k = 0; k < nsamp; k++) begin
            @(negedge CLK);
            oen_s[k]  = O_EN;
            odat_s[k] = O_DAT;
            if (k == 0) TX_DATA = 8'hC3;
            if (k == F + T + 1) TX_VALID = 1'b0;
        end
        gap = 0;
        for (int k = F; k < nsamp && oen_s[k]; k++) gap++;
        check("b2b_gap", 32'(gap), 32'(T + 1));
        for (int i = 0; i < F; i++) begin
            check("b2b_w1_bit", 32'({oen_s[i], odat_s[i]}),
                  32'({1'b0, model_frame(8'h5A)[F-1-i]}));
            check("b2b_w2_bit", 32'({oen_s[F+T+1+i], odat_s[F+T+1+i]}),
                  32'({1'b0, model_frame(8'hC3)[F-1-i]}));
        end

        // Randomized frames with noise on the request inputs.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                line = F'($urandom);
                rx_frame(line, model_rx_data(line), model_rx_perr(line), 1);
            end else begin
                w = W'($urandom);
                tx_frame(w, model_frame(w), 1'($urandom_range(0, 1)), 1);
            end
        end

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdiomux_xcvr.md
SDIOMUX_XCVR -- requirements
Module: sdiomux_xcvr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting the frame data width in bits (range 2..32).
REQ-002 SHALL have parameter TURN_CYCLES, default 2, setting the bus-turnaround gap in cycles during which both pad enables are released (range 1..15).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port TX_DATA, input, WIDTH bits: word to transmit, MSB first.
REQ-006 SHALL have port TX_VALID, input, 1 bit: transmit request.
REQ-007 SHALL have port TX_READY, output, 1 bit: high only in IDLE; a transfer occurs when TX_VALID and TX_READY are both high at an edge.
REQ-008 SHALL have port RX_START, input, 1 bit: receive request, sampled in IDLE only.
REQ-009 SHALL have port RX_DATA, output, WIDTH bits: last received word.
REQ-010 SHALL have port RX_VALID, output, 1 bit: one-cycle pulse when RX_DATA updates.
REQ-011 SHALL have port RX_PERR, output, 1 bit: parity error flag for the current RX_DATA.
REQ-012 SHALL have port O_DAT, output, 1 bit: feeds the pad cell O_DAT.
REQ-013 SHALL have port O_EN, output, 1 bit: feeds the pad cell O_EN; active-low drive enable.
REQ-014 SHALL have port I_EN, output, 1 bit: feeds the pad cell I_EN; active-low input enable.
REQ-015 SHALL have port I_DAT, input, 1 bit: driven by the pad cell I_DAT; asynchronous to CLK.
REQ-016 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL register all outputs; no combinational path from any input to any output.
REQ-018 SHALL implement an FSM with states IDLE, TX, RX, and TURN.
REQ-019 In IDLE, on a TX_VALID&&TX_READY edge, the FSM SHALL enter TX, latch TX_DATA, and set O_EN=0 and O_DAT=TX_DATA[WIDTH-1] at that edge.
REQ-020 TX SHALL last exactly F cycles (F=WIDTH, or WIDTH+1 with parity), presenting one bit per cycle MSB first, with O_EN=0 and I_EN=1 throughout.
REQ-021 On leaving TX, the FSM SHALL enter TURN with O_EN=1 and O_DAT=0.
REQ-022 In IDLE, with RX_START high and TX_VALID low, the FSM SHALL enter RX with I_EN=0 at that edge.
REQ-023 If TX_VALID and RX_START are high together in IDLE, TX SHALL win and RX_START SHALL be dropped.
REQ-024 I_DAT SHALL pass through a 2-flop synchronizer.
REQ-025 RX SHALL last F+2 cycles with I_EN=0; the first 2 synchronizer outputs SHALL be discarded and the next F shifted in MSB first.
REQ-026 At the edge leaving RX, RX_DATA SHALL update, RX_VALID SHALL pulse for 1 cycle, I_EN SHALL return to 1, and the FSM SHALL enter TURN.
REQ-027 TURN SHALL last exactly TURN_CYCLES cycles with O_EN=1 and I_EN=1, then return to IDLE.
REQ-028 O_EN=0 and I_EN=0 SHALL never occur in the same cycle.
REQ-029 TX_VALID and RX_START outside IDLE SHALL be ignored; RX_DATA and RX_PERR SHALL hold between receptions.
REQ-030 TX_VALID held high continuously SHALL yield back-to-back frames separated by exactly TURN_CYCLES+1 cycles of O_EN=1 (TURN plus the IDLE accept cycle).

Reset
REQ-031 RST SHALL force: state=IDLE, O_DAT=0, O_EN=1, I_EN=1, RX_DATA=0, RX_VALID=0, RX_PERR=0, and all synchronizer flops, shift registers, and counters to 0.
REQ-032 RST mid-TX or mid-RX SHALL abort the frame; pad enables SHALL be released at that edge, and no RX_VALID SHALL be produced.
REQ-033 TX_READY SHALL be high in the first cycle after reset deasserts.

Configuration
REQ-034 Macro SDIOMUX_XCVR_PARITY_EN SHALL, when defined, set F=WIDTH+1: TX appends an even-parity bit after the LSB; RX checks it and sets RX_PERR=1 on mismatch, updated with RX_VALID.
REQ-035 Without SDIOMUX_XCVR_PARITY_EN, F SHALL equal WIDTH, RX_PERR SHALL be tied 0, and the port SHALL still exist.

Verification
REQ-036 A bench SHALL cover: TX 0xA5, WIDTH=8, no parity -> O_DAT 1,0,1,0,0,1,0,1 over 8 cycles with O_EN=0, then 2 cycles with O_EN=I_EN=1, then TX_READY=1.
REQ-037 A bench SHALL cover: RX_START, then remote drives 0x3C aligned to REQ-025 -> RX_DATA=0x3C, single-cycle RX_VALID, I_EN=0 for exactly 10 cycles.
REQ-038 A bench SHALL cover: TX_VALID and RX_START in the same IDLE cycle with TX_DATA=0xFF -> TX frame, no RX, I_EN stays 1.
REQ-039 A bench SHALL cover: RST asserted after 3 TX bits -> O_EN=1 at the next edge, BUSY=0, TX_READY=1 after release, and no further O_DAT toggles.
REQ-040 A bench SHALL cover, with the macro defined: TX 0x07 -> 9th bit 1; RX 0x07 with parity bit 0 -> RX_PERR=1 together with RX_VALID.
REQ-041 A bench SHALL cover: TX_VALID held high for two words -> 3-cycle O_EN=1 gap between frames, and O_EN/I_EN never both 0 at any time.
